// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus bundle: Program_Rom drive/return signals plus the decode handshake.
// master = fetch_sequencer, slave = ROM/decode side.
interface fetch_sequencer_if #(
  parameter int ADDR_W = 14
);
  logic [ADDR_W-1:0] Rom_addr_in;
  logic              pc_1;
  logic              sel_mem_1;
  logic [1:0]        sel_mem_0;
  logic [15:0]       IR_0;
  logic [15:0]       IR_1;
  logic [15:0]       inst0;
  logic [15:0]       inst1;
  logic              inst0_valid;
  logic              inst1_valid;
  logic [ADDR_W:0]   inst0_pc;
  logic [1:0]        dec_take;
  logic              branch_valid;
  logic [ADDR_W:0]   branch_target;
  logic              halt;
  logic              done;

  modport master (
    output Rom_addr_in, pc_1, sel_mem_1, sel_mem_0,
    output inst0, inst1, inst0_valid, inst1_valid, inst0_pc, done,
    input  IR_0, IR_1, dec_take, branch_valid, branch_target, halt
  );

  modport slave (
    input  Rom_addr_in, pc_1, sel_mem_1, sel_mem_0,
    input  inst0, inst1, inst0_valid, inst1_valid, inst0_pc, done,
    output IR_0, IR_1, dec_take, branch_valid, branch_target, halt
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Dual-bank Program_Rom fetch controller: holds the halfword PC, steers the ROM banks so
// slot 0/1 present PC and PC+1, and handles take-count, redirect bubbles, halt and end.
//
// state      | meaning
// S_IDLE     | one cycle after reset before fetch starts
// S_RUN      | slots offered to decode, pc advances by dec_take
// S_REDIRECT | bubble after branch/halt exit, cnt counts down to 0
// S_HALTED   | fetch stopped by halt, waits for a branch
// S_END      | pc left the program, done=1, waits for a branch
module fetch_sequencer #(
  parameter int ADDR_W          = 14,
  parameter int RESET_PC        = 0,
  parameter int PROG_LEN        = 15,
  parameter int REDIRECT_CYCLES = 1
) (
  input logic             clk,
  input logic             rst,
  fetch_sequencer_if.master bus
);

  localparam int PC_W  = ADDR_W + 1;
  localparam int RC_M1 = (REDIRECT_CYCLES > 0) ? REDIRECT_CYCLES - 1 : 0;

  localparam logic [PC_W:0]   LEN_W    = PROG_LEN[PC_W:0];
  localparam logic [PC_W-1:0] PC_RST   = RESET_PC[PC_W-1:0];
  localparam logic [2:0]      CNT_LOAD = RC_M1[2:0];

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_REDIRECT,
    S_HALTED,
    S_END
  } state_t;

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc, pc_nxt;
  logic [2:0]      cnt, cnt_nxt;

  logic [PC_W:0]   pc_ext;
  logic [PC_W:0]   pc_plus1;
  logic [PC_W:0]   pc_sum;
  logic            in_run;
  logic            slot0_ok;
  logic            slot1_ok;
  logic [1:0]      valid_cnt;
  logic            take_ok;
  logic [1:0]      eff_take;
  logic            halt_ok;
  logic            branch_ok;

  // Compare one bit wider than the PC so an out-of-program PC never wraps back into range.
  assign pc_ext    = {1'b0, pc};
  assign pc_plus1  = pc_ext + {{PC_W{1'b0}}, 1'b1};
  assign in_run    = (state == S_RUN);
  assign slot0_ok  = in_run && (pc_ext < LEN_W);
  assign slot1_ok  = in_run && (pc_plus1 < LEN_W);
  assign valid_cnt = {1'b0, slot0_ok} + {1'b0, slot1_ok};
  assign take_ok   = (bus.dec_take <= valid_cnt);
  assign eff_take  = take_ok ? bus.dec_take : 2'd0;
  assign pc_sum    = pc_ext + {{(PC_W-1){1'b0}}, eff_take};
  assign halt_ok   = bus.halt && ((state == S_RUN) || (state == S_REDIRECT) || (state == S_END));
  assign branch_ok = bus.branch_valid && (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      pc    <= PC_RST;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    cnt_nxt   = cnt;
    if (state == S_IDLE) begin
      state_nxt = S_RUN;
    end else if (halt_ok) begin
      state_nxt = S_HALTED;
    end else if (branch_ok) begin
      pc_nxt = bus.branch_target;
      if (REDIRECT_CYCLES == 0) begin
        state_nxt = S_RUN;
      end else begin
        state_nxt = S_REDIRECT;
        cnt_nxt   = CNT_LOAD;
      end
    end else begin
      unique case (state)
        S_RUN: begin
          pc_nxt = pc_sum[PC_W-1:0];
          if (pc_sum >= LEN_W) state_nxt = S_END;
        end
        S_REDIRECT: begin
          if (cnt == 3'd0) state_nxt = S_RUN;
          else             cnt_nxt   = cnt - 3'd1;
        end
        default: begin
        end
      endcase
    end
  end

  // Bank 0 holds even halfwords; an odd pc reads slot 1 from the next bank-0 row.
  assign bus.Rom_addr_in = pc[PC_W-1:1];
  assign bus.pc_1        = pc[0];
  assign bus.sel_mem_0   = pc[0] ? 2'd2 : 2'd0;
  assign bus.sel_mem_1   = ~pc[0];

  assign bus.inst0       = bus.IR_0;
  assign bus.inst1       = bus.IR_1;
  assign bus.inst0_pc    = pc;
  assign bus.inst0_valid = slot0_ok;
  assign bus.inst1_valid = slot1_ok;
  assign bus.done        = (state == S_END);

  // Decode may never consume more instructions than were offered.
  a_take_legal: assert property (@(posedge clk) disable iff (rst)
    (in_run && !bus.halt && !bus.branch_valid) |-> take_ok);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: Program_Rom bank model, directed scenarios
// and a randomized run against a behavioural fetch model.
module tb_fetch_sequencer;

  localparam int ADDR_W   = 14;
  localparam int PROG_LEN = 15;
  localparam int RC       = 1;

  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_REDIR  = 2;
  localparam int M_HALTED = 3;
  localparam int M_END    = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_sequencer_if #(.ADDR_W(ADDR_W)) bus();

  fetch_sequencer #(
    .ADDR_W(ADDR_W), .RESET_PC(0), .PROG_LEN(PROG_LEN), .REDIRECT_CYCLES(RC)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Program image as halfwords; banks are derived from it.
  logic [15:0] rom_img [0:31];
  logic [3:0]  row;
  logic [3:0]  row_b0;
  assign row    = bus.Rom_addr_in[3:0];
  assign row_b0 = row + {3'b000, bus.pc_1};
  assign bus.IR_0 = (bus.sel_mem_0 == 2'd0) ? rom_img[{row_b0, 1'b0}] :
                    (bus.sel_mem_0 == 2'd2) ? rom_img[{row, 1'b1}]    : 16'hDEAD;
  assign bus.IR_1 = bus.sel_mem_1 ? rom_img[{row, 1'b1}] : rom_img[{row_b0, 1'b0}];

  int m_mode;
  int m_pc;
  int m_cnt;

  function automatic int m_vcount();
    int v = 0;
    if (m_mode == M_RUN) begin
      if (m_pc < PROG_LEN)     v++;
      if (m_pc + 1 < PROG_LEN) v++;
    end
    return v;
  endfunction

  function automatic void model_reset();
    m_mode = M_IDLE;
    m_pc   = 0;
    m_cnt  = 0;
  endfunction

  function automatic void model_update(int take, bit br, int tgt, bit hlt);
    int vc = m_vcount();
    if (m_mode == M_IDLE) m_mode = M_RUN;
    else if (hlt && m_mode != M_HALTED) m_mode = M_HALTED;
    else if (br) begin
      m_pc = tgt;
      if (RC == 0) m_mode = M_RUN;
      else begin
        m_mode = M_REDIR;
        m_cnt  = RC - 1;
      end
    end else if (m_mode == M_RUN) begin
      if (take > vc) take = 0;
      if (m_pc + take >= PROG_LEN) m_mode = M_END;
      m_pc = (m_pc + take) % 32768;
    end else if (m_mode == M_REDIR) begin
      if (m_cnt == 0) m_mode = M_RUN;
      else m_cnt--;
    end
  endfunction

  // Apply inputs for one rising edge; returns at the following falling edge.
  task automatic step(input int take, input bit br, input int tgt, input bit hlt);
    bus.dec_take      = 2'(take);
    bus.branch_valid  = br;
    bus.branch_target = 15'(tgt);
    bus.halt          = hlt;
    @(posedge clk);
    model_update(take, br, tgt, hlt);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.dec_take = 2'd0; bus.branch_valid = 1'b0; bus.branch_target = '0; bus.halt = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    n_checks++;
    if (bus.inst0_valid !== 1'b0 || bus.inst1_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valids: got %b%b want 00", bus.inst0_valid, bus.inst1_valid);
    end
    n_checks++;
    if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_checks++;
    if (bus.inst0_pc !== 15'd0) begin n_fail++; $display("FAIL reset_pc: got %0d want 0", bus.inst0_pc); end
  endtask

  task automatic test_startup();
    bus.dec_take = 2'd2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.inst0_valid !== 1'b0 || bus.inst1_valid !== 1'b0) begin
      n_fail++; $display("FAIL idle_valids: got %b%b want 00", bus.inst0_valid, bus.inst1_valid);
    end
    step(2, 0, 0, 0);
    n_checks++;
    if (bus.inst0 !== 16'h2070 || bus.inst1 !== 16'h0600 || bus.inst0_valid !== 1'b1 || bus.inst1_valid !== 1'b1) begin
      n_fail++; $display("FAIL pc0_slots: got %h/%h v%b%b want 2070/0600 v11", bus.inst0, bus.inst1, bus.inst0_valid, bus.inst1_valid);
    end
    n_checks++;
    if (bus.sel_mem_0 !== 2'd0 || bus.sel_mem_1 !== 1'b1) begin
      n_fail++; $display("FAIL pc0_sel: got %0d/%0d want 0/1", bus.sel_mem_0, bus.sel_mem_1);
    end
    step(2, 0, 0, 0);
    n_checks++;
    if (bus.inst0_pc !== 15'd2 || bus.inst0 !== 16'h2170 || bus.inst1 !== 16'h0609) begin
      n_fail++; $display("FAIL pc2_slots: got pc%0d %h/%h want pc2 2170/0609", bus.inst0_pc, bus.inst0, bus.inst1);
    end
    step(0, 0, 0, 0);
    n_checks++;
    if (bus.inst0_pc !== 15'd2 || bus.inst0_valid !== 1'b1) begin
      n_fail++; $display("FAIL take0_hold: got pc%0d v%b want pc2 v1", bus.inst0_pc, bus.inst0_valid);
    end
  endtask

  task automatic test_odd_pc();
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    n_checks++;
    if (bus.Rom_addr_in !== 14'd0 || bus.pc_1 !== 1'b1 || bus.sel_mem_0 !== 2'd2 || bus.sel_mem_1 !== 1'b0) begin
      n_fail++; $display("FAIL pc1_drive: got row%0d pc_1=%b sel %0d/%0d want row0 pc_1=1 sel 2/0",
                         bus.Rom_addr_in, bus.pc_1, bus.sel_mem_0, bus.sel_mem_1);
    end
    n_checks++;
    if (bus.inst0 !== 16'h0600 || bus.inst1 !== 16'h2170) begin
      n_fail++; $display("FAIL pc1_slots: got %h/%h want 0600/2170", bus.inst0, bus.inst1);
    end
  endtask

  task automatic test_branch();
    step(2, 1, 5, 0);
    n_checks++;
    if (bus.inst0_valid !== 1'b0 || bus.inst1_valid !== 1'b0) begin
      n_fail++; $display("FAIL redirect_bubble: got %b%b want 00", bus.inst0_valid, bus.inst1_valid);
    end
    step(0, 0, 0, 0);
    n_checks++;
    if (bus.inst0_pc !== 15'd5 || bus.inst0 !== 16'h2090 || bus.inst1 !== 16'h0600 || bus.inst0_valid !== 1'b1) begin
      n_fail++; $display("FAIL branch_target: got pc%0d %h/%h v%b want pc5 2090/0600 v1",
                         bus.inst0_pc, bus.inst0, bus.inst1, bus.inst0_valid);
    end
  endtask

  task automatic test_end();
    step(0, 1, 14, 0);
    step(0, 0, 0, 0);
    n_checks++;
    if (bus.inst0 !== 16'h1842 || bus.inst0_valid !== 1'b1 || bus.inst1_valid !== 1'b0) begin
      n_fail++; $display("FAIL last_inst: got %h v%b%b want 1842 v10", bus.inst0, bus.inst0_valid, bus.inst1_valid);
    end
    step(1, 0, 0, 0);
    n_checks++;
    if (bus.done !== 1'b1 || bus.inst0_valid !== 1'b0 || bus.inst1_valid !== 1'b0) begin
      n_fail++; $display("FAIL end_state: got done%b v%b%b want done1 v00", bus.done, bus.inst0_valid, bus.inst1_valid);
    end
    step(0, 0, 0, 0);
    n_checks++;
    if (bus.done !== 1'b1) begin n_fail++; $display("FAIL end_hold: got done%b want 1", bus.done); end
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    n_checks++;
    if (bus.inst0 !== 16'h2070 || bus.inst0_valid !== 1'b1 || bus.done !== 1'b0) begin
      n_fail++; $display("FAIL end_refetch: got %h v%b done%b want 2070 v1 done0", bus.inst0, bus.inst0_valid, bus.done);
    end
  endtask

  task automatic test_halt();
    step(0, 1, 4, 0);
    step(0, 0, 0, 0);
    step(2, 1, 9, 1);
    n_checks++;
    if (bus.inst0_pc !== 15'd4 || bus.inst0_valid !== 1'b0 || bus.inst1_valid !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++; $display("FAIL halt_prio: got pc%0d v%b%b done%b want pc4 v00 done0",
                         bus.inst0_pc, bus.inst0_valid, bus.inst1_valid, bus.done);
    end
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    n_checks++;
    if (bus.inst0_pc !== 15'd4 || bus.inst0_valid !== 1'b0) begin
      n_fail++; $display("FAIL halt_hold: got pc%0d v%b want pc4 v0", bus.inst0_pc, bus.inst0_valid);
    end
    step(0, 1, 0, 0);
    n_checks++;
    if (bus.inst0_valid !== 1'b0) begin n_fail++; $display("FAIL halt_exit_bubble: got v%b want 0", bus.inst0_valid); end
    step(0, 0, 0, 0);
    n_checks++;
    if (bus.inst0_pc !== 15'd0 || bus.inst0_valid !== 1'b1 || bus.inst0 !== 16'h2070) begin
      n_fail++; $display("FAIL halt_exit_run: got pc%0d v%b %h want pc0 v1 2070", bus.inst0_pc, bus.inst0_valid, bus.inst0);
    end
  endtask

  task automatic test_random();
    int take;
    bit br, hlt;
    int tgt;
    for (int i = 0; i < 800; i++) begin
      hlt  = ($urandom_range(19) == 0);
      br   = ($urandom_range(7) == 0);
      tgt  = $urandom_range(18);
      take = (m_mode == M_RUN) ? $urandom_range(m_vcount()) : $urandom_range(2);
      step(take, br, tgt, hlt);
      n_checks++;
      if (bus.inst0_pc !== 15'(m_pc)) begin
        n_fail++; $display("FAIL rnd_pc[%0d]: got %0d want %0d", i, bus.inst0_pc, m_pc);
      end
      n_checks++;
      if (bus.inst0_valid !== (m_mode == M_RUN && m_pc < PROG_LEN) ||
          bus.inst1_valid !== (m_mode == M_RUN && m_pc + 1 < PROG_LEN)) begin
        n_fail++; $display("FAIL rnd_valid[%0d]: got %b%b want mode%0d pc%0d", i, bus.inst0_valid, bus.inst1_valid, m_mode, m_pc);
      end
      n_checks++;
      if (bus.done !== (m_mode == M_END)) begin
        n_fail++; $display("FAIL rnd_done[%0d]: got %b want %b", i, bus.done, m_mode == M_END);
      end
      n_checks++;
      if (bus.inst0 !== rom_img[m_pc % 32] || bus.inst1 !== rom_img[(m_pc + 1) % 32]) begin
        n_fail++; $display("FAIL rnd_inst[%0d]: got %h/%h want %h/%h", i, bus.inst0, bus.inst1,
                           rom_img[m_pc % 32], rom_img[(m_pc + 1) % 32]);
      end
    end
  endtask

  task automatic test_async_reset();
    step(0, 1, 3, 0);
    step(0, 0, 0, 0);
    n_checks++;
    if (bus.inst0_valid !== 1'b1) begin n_fail++; $display("FAIL arst_pre: got v%b want 1", bus.inst0_valid); end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (bus.inst0_valid !== 1'b0 || bus.inst1_valid !== 1'b0 || bus.inst0_pc !== 15'd0) begin
      n_fail++; $display("FAIL arst_immediate: got v%b%b pc%0d want v00 pc0", bus.inst0_valid, bus.inst1_valid, bus.inst0_pc);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(0, 0, 0, 0);
    n_checks++;
    if (bus.inst0_pc !== 15'd0 || bus.inst0_valid !== 1'b1 || bus.inst0 !== 16'h2070) begin
      n_fail++; $display("FAIL arst_restart: got pc%0d v%b %h want pc0 v1 2070", bus.inst0_pc, bus.inst0_valid, bus.inst0);
    end
  endtask

  initial begin
    rom_img[0]  = 16'h2070; rom_img[1]  = 16'h0600; rom_img[2]  = 16'h2170; rom_img[3]  = 16'h0609;
    rom_img[4]  = 16'h2270; rom_img[5]  = 16'h2090; rom_img[6]  = 16'h0600; rom_img[7]  = 16'h2190;
    rom_img[8]  = 16'h0612; rom_img[9]  = 16'h2290; rom_img[10] = 16'h0618; rom_img[11] = 16'h3001;
    rom_img[12] = 16'h4102; rom_img[13] = 16'h0700; rom_img[14] = 16'h1842;
    for (int k = 15; k < 32; k++) rom_img[k] = 16'hA000 + 16'(k);
    test_reset();
    test_startup();
    test_odd_pc();
    test_branch();
    test_end();
    test_halt();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
